// File: rtl/clock_ctrl_pkg.sv
// Shared types and BCD helpers for the clock time-setting controller.
// Fields are two-digit BCD {tens,units}; the helpers wrap at a caller-supplied limit.
package clock_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_H  = 3'd1,
    ST_SET_M  = 3'd2,
    ST_SET_S  = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if (v >= lim) begin
      r = 8'h00;
    end else if (v[3:0] >= 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if ((v == 8'h00) || (v > lim)) begin
      r = lim;
    end else if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // A captured field that is not a legal BCD value within range becomes zero.
  function automatic logic [7:0] bcd_check(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v > lim)) begin
      r = 8'h00;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and press pulse.
// The pulse is decoded on the last stable sample so the consumer acts DEB_CYC+2 edges after the raw edge.
module key_debounce #(
  parameter int DEB_CYC = 20
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // Synchronise the raw level and accept it after DEB_CYC identical samples.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= CNT_ZERO;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= CNT_ZERO;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= CNT_ZERO;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign press = r_stable & ~r_sync2 & (r_cnt == CNT_LAST);

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: freezes the time counter, edits HH:MM:SS in BCD,
// blinks the field being edited and strobes the edited time back on commit.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 1000,
  parameter int DEBOUNCE_MS = 20,
  parameter int BLINK_HALF  = 250,
  parameter int TIMEOUT_S   = 30
) (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  input  logic       key_dec_n,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  output logic       cnt_en,
  output logic       load,
  output logic [7:0] set_hh,
  output logic [7:0] set_mm,
  output logic [7:0] set_ss,
  output logic [5:0] blank
);

  localparam int DEB_CYC = CLK_HZ * DEBOUNCE_MS / 1000;
  localparam int TO_CYC  = CLK_HZ * TIMEOUT_S;
  localparam int BW      = $clog2(BLINK_HALF);
  localparam int TW      = $clog2(TO_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
  localparam logic [BW-1:0] BLINK_ZERO = BW'(0);
  localparam logic [TW-1:0] TO_LAST    = TW'(TO_CYC - 1);
  localparam logic [TW-1:0] TO_ONE     = TW'(1);
  localparam logic [TW-1:0] TO_ZERO    = TW'(0);

  logic w_mode, w_inc, w_dec, w_any;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (.clk1(clk1), .rst_n(rst_n), .key_n(key_mode_n), .press(w_mode));
  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_inc  (.clk1(clk1), .rst_n(rst_n), .key_n(key_inc_n),  .press(w_inc));
  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_dec  (.clk1(clk1), .rst_n(rst_n), .key_n(key_dec_n),  .press(w_dec));

  assign w_any = w_mode | w_inc | w_dec;

  state_t        r_state, w_nxt_state;
  logic [7:0]    r_set_hh, r_set_mm, r_set_ss;
  logic [7:0]    w_nxt_hh, w_nxt_mm, w_nxt_ss;
  logic [BW-1:0] r_blink_cnt, w_nxt_blink_cnt;
  logic          r_phase, w_nxt_phase;
  logic [TW-1:0] r_to_cnt, w_nxt_to_cnt;
  logic          w_clr_blink;

  // State, edit buffer, blink and idle-timeout registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_set_hh    <= 8'h00;
      r_set_mm    <= 8'h00;
      r_set_ss    <= 8'h00;
      r_blink_cnt <= BLINK_ZERO;
      r_phase     <= 1'b0;
      r_to_cnt    <= TO_ZERO;
    end else begin
      r_state     <= w_nxt_state;
      r_set_hh    <= w_nxt_hh;
      r_set_mm    <= w_nxt_mm;
      r_set_ss    <= w_nxt_ss;
      r_blink_cnt <= w_nxt_blink_cnt;
      r_phase     <= w_nxt_phase;
      r_to_cnt    <= w_nxt_to_cnt;
    end
  end

  // Mode sequencing, BCD edits, blink restart and timeout; mode outranks inc/dec.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_hh     = r_set_hh;
    w_nxt_mm     = r_set_mm;
    w_nxt_ss     = r_set_ss;
    w_nxt_to_cnt = r_to_cnt + TO_ONE;
    w_clr_blink  = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_clr_blink  = 1'b1;
        w_nxt_to_cnt = TO_ZERO;
        if (w_mode) begin
          w_nxt_state = ST_SET_H;
          w_nxt_hh    = bcd_check(cur_hh, HH_MAX);
          w_nxt_mm    = bcd_check(cur_mm, MS_MAX);
          w_nxt_ss    = bcd_check(cur_ss, MS_MAX);
        end else begin
          w_nxt_state = ST_RUN;
        end
      end
      ST_SET_H, ST_SET_M, ST_SET_S: begin
        if (w_any) begin
          w_nxt_to_cnt = TO_ZERO;
        end else begin
          w_nxt_to_cnt = r_to_cnt + TO_ONE;
        end
        if (w_mode) begin
          w_clr_blink = 1'b1;
          case (r_state)
            ST_SET_H: w_nxt_state = ST_SET_M;
            ST_SET_M: w_nxt_state = ST_SET_S;
            default:  w_nxt_state = ST_COMMIT;
          endcase
        end else if (w_inc ^ w_dec) begin
          w_clr_blink = 1'b1;
          case (r_state)
            ST_SET_H: w_nxt_hh = w_inc ? bcd_inc(r_set_hh, HH_MAX) : bcd_dec(r_set_hh, HH_MAX);
            ST_SET_M: w_nxt_mm = w_inc ? bcd_inc(r_set_mm, MS_MAX) : bcd_dec(r_set_mm, MS_MAX);
            default:  w_nxt_ss = w_inc ? bcd_inc(r_set_ss, MS_MAX) : bcd_dec(r_set_ss, MS_MAX);
          endcase
        end else if (!w_any && (r_to_cnt == TO_LAST)) begin
          w_nxt_state = ST_RUN;
        end else begin
          w_nxt_state = r_state;
        end
      end
      ST_COMMIT: begin
        w_nxt_state  = ST_RUN;
        w_nxt_to_cnt = TO_ZERO;
        w_clr_blink  = 1'b1;
      end
      default: begin
        w_nxt_state  = ST_RUN;
        w_nxt_to_cnt = TO_ZERO;
        w_clr_blink  = 1'b1;
      end
    endcase

    if (w_clr_blink) begin
      w_nxt_blink_cnt = BLINK_ZERO;
      w_nxt_phase     = 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      w_nxt_blink_cnt = BLINK_ZERO;
      w_nxt_phase     = ~r_phase;
    end else begin
      w_nxt_blink_cnt = r_blink_cnt + BLINK_ONE;
      w_nxt_phase     = r_phase;
    end
  end

  // Blank mask: only the active field follows the blink phase.
  always_comb begin
    case (r_state)
      ST_SET_H: blank = {r_phase, r_phase, 4'b0000};
      ST_SET_M: blank = {2'b00, r_phase, r_phase, 2'b00};
      ST_SET_S: blank = {4'b0000, r_phase, r_phase};
      default:  blank = 6'b000000;
    endcase
  end

  assign cnt_en = (r_state == ST_RUN);
  assign load   = (r_state == ST_COMMIT);
  assign set_hh = r_set_hh;
  assign set_mm = r_set_mm;
  assign set_ss = r_set_ss;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: stimulus queues expectations, a negedge
// monitor compares them and checks every load strobe against expected commits.
module tb_clock_set_ctrl;

  localparam int K_MODE = 0;
  localparam int K_INC  = 1;
  localparam int K_DEC  = 2;

  localparam int S_CNT_EN = 0;
  localparam int S_LOAD   = 1;
  localparam int S_BLANK  = 2;
  localparam int S_SET    = 3;
  localparam int S_PEND   = 4;

  logic       clk1 = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_mode_n = 1'b1;
  logic       key_inc_n = 1'b1;
  logic       key_dec_n = 1'b1;
  logic [7:0] cur_hh = 8'h00;
  logic [7:0] cur_mm = 8'h00;
  logic [7:0] cur_ss = 8'h00;
  logic       cnt_en, load;
  logic [7:0] set_hh, set_mm, set_ss;
  logic [5:0] blank;

  int total = 0;
  int bad = 0;

  string       q_name[$];
  int          q_sel[$];
  logic [23:0] q_exp[$];
  logic [23:0] load_q[$];

  clock_set_ctrl #(
    .CLK_HZ(1000), .DEBOUNCE_MS(4), .BLINK_HALF(8), .TIMEOUT_S(1)
  ) dut (
    .clk1(clk1), .rst_n(rst_n),
    .key_mode_n(key_mode_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
    .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_ss(cur_ss),
    .cnt_en(cnt_en), .load(load),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .blank(blank)
  );

  always #5 clk1 = ~clk1;

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string nm, input int sel, input logic [23:0] e);
    q_name.push_back(nm);
    q_sel.push_back(sel);
    q_exp.push_back(e);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      K_MODE:  key_mode_n = v;
      K_INC:   key_inc_n  = v;
      default: key_dec_n  = v;
    endcase
  endtask

  // Pulse is consumed on the sixth edge after the raw falling edge.
  task automatic key_down(input int k);
    set_key(k, 1'b0);
    repeat (6) step();
  endtask

  task automatic key_up(input int k);
    repeat (3) step();
    set_key(k, 1'b1);
    repeat (8) step();
  endtask

  task automatic press(input int k);
    key_down(k);
    key_up(k);
  endtask

  // Monitor: compares load strobes and queued snapshot expectations.
  initial begin
    logic [23:0] act, e;
    int          sel;
    string       nm;
    forever begin
      @(negedge clk1);
      if (load === 1'b1) begin
        total++;
        if (load_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_load: got set=%h%h%h, required no load", set_hh, set_mm, set_ss);
        end else begin
          e = load_q.pop_front();
          if ({set_hh, set_mm, set_ss} !== e) begin
            bad++;
            $display("FAIL load_value: got %h%h%h, required %h", set_hh, set_mm, set_ss, e);
          end
        end
      end
      while (q_sel.size() > 0) begin
        sel = q_sel.pop_front();
        nm  = q_name.pop_front();
        e   = q_exp.pop_front();
        case (sel)
          S_CNT_EN: act = {23'd0, cnt_en};
          S_LOAD:   act = {23'd0, load};
          S_BLANK:  act = {18'd0, blank};
          S_SET:    act = {set_hh, set_mm, set_ss};
          S_PEND:   act = 24'(load_q.size());
          default:  act = 24'hxxxxxx;
        endcase
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL %s: got %h, required %h", nm, act, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    repeat (2) step();
    chk("cnt_en_in_reset", S_CNT_EN, 24'h1);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_cnt_en", S_CNT_EN, 24'h1);
    chk("rst_load", S_LOAD, 24'h0);
    chk("rst_blank", S_BLANK, 24'h0);
    chk("rst_set", S_SET, 24'h000000);

    // Short glitch on mode must be filtered
    key_mode_n = 1'b0;
    repeat (2) step();
    key_mode_n = 1'b1;
    repeat (10) step();
    chk("glitch_cnt_en", S_CNT_EN, 24'h1);
    chk("glitch_blank", S_BLANK, 24'h0);

    // Session A: capture 12:34:56, entry latency, blink, hours wrap, timeout
    cur_hh = 8'h12; cur_mm = 8'h34; cur_ss = 8'h56;
    key_mode_n = 1'b0;
    repeat (5) step();
    chk("pre_entry_cnt_en", S_CNT_EN, 24'h1);
    step();
    chk("entry_cnt_en", S_CNT_EN, 24'h0);
    chk("capture_a", S_SET, 24'h123456);
    chk("entry_blank", S_BLANK, 24'h0);
    repeat (4) step();
    key_mode_n = 1'b1;
    repeat (3) step();
    chk("blink_e7", S_BLANK, 24'h0);
    step();
    chk("blink_e8", S_BLANK, 24'h000030);
    repeat (8) step();
    chk("blink_e16", S_BLANK, 24'h0);

    for (int i = 0; i < 12; i++) press(K_INC);
    chk("hh_wrap_up", S_SET, 24'h003456);
    key_down(K_DEC);
    chk("hh_wrap_down", S_SET, 24'h233456);
    repeat (7) step();
    chk("adj_blink_d7", S_BLANK, 24'h0);
    step();
    chk("adj_blink_d8", S_BLANK, 24'h000030);
    key_up(K_DEC);

    key_down(K_MODE);
    key_up(K_MODE);
    repeat (988) step();
    chk("timeout_not_yet", S_CNT_EN, 24'h0);
    step();
    chk("timeout_run", S_CNT_EN, 24'h1);
    chk("timeout_no_load", S_LOAD, 24'h0);
    chk("timeout_set_kept", S_SET, 24'h233456);
    chk("timeout_blank", S_BLANK, 24'h0);

    // Session B: invalid hour capture, wraps, commit 23:00:59
    cur_hh = 8'h2A; cur_mm = 8'h59; cur_ss = 8'h58;
    key_down(K_MODE);
    chk("capture_invalid_hh", S_SET, 24'h005958);
    key_up(K_MODE);
    press(K_DEC);
    chk("hh_00_dec", S_SET, 24'h235958);
    press(K_MODE);
    press(K_INC);
    chk("mm_59_inc", S_SET, 24'h230058);
    press(K_MODE);
    press(K_INC);
    chk("ss_58_inc", S_SET, 24'h230059);
    load_q.push_back(24'h230059);
    key_down(K_MODE);
    chk("commit_load", S_LOAD, 24'h1);
    chk("commit_cnt_en", S_CNT_EN, 24'h0);
    step();
    chk("post_commit_cnt_en", S_CNT_EN, 24'h1);
    chk("post_commit_load", S_LOAD, 24'h0);
    key_up(K_MODE);
    chk("commit_consumed", S_PEND, 24'h0);

    // Session C: BCD carry/borrow in minutes, then reset mid-edit
    cur_hh = 8'h08; cur_mm = 8'h09; cur_ss = 8'h10;
    press(K_MODE);
    chk("capture_c", S_SET, 24'h080910);
    press(K_MODE);
    press(K_INC);
    chk("mm_carry", S_SET, 24'h081010);
    press(K_DEC);
    chk("mm_borrow", S_SET, 24'h080910);
    key_down(K_MODE);
    repeat (8) step();
    chk("ss_blink", S_BLANK, 24'h000003);
    key_up(K_MODE);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("midedit_rst_cnt_en", S_CNT_EN, 24'h1);
    chk("midedit_rst_blank", S_BLANK, 24'h0);
    chk("midedit_rst_set", S_SET, 24'h000000);
    chk("midedit_rst_load", S_LOAD, 24'h0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("after_rst_cnt_en", S_CNT_EN, 24'h1);
    chk("no_pending_load", S_PEND, 24'h0);
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
